// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: sync byte, FSM states and error codes.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CSUM,
    RUN,
    ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CSUM = 2'd2,
    ERR_TMO  = 2'd3
  } err_t;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer: first byte loaded ends up in bits [31:24].
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0] cnt;

  // word_done flags the load that completes a word; the full word is visible next cycle
  assign word_done = load && (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word <= '0;
      cnt  <= '0;
    end else if (load) begin
      word <= {word[23:0], din};
      cnt  <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: packs payload into instruction memory and releases the core on a good checksum.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned IMEM_WORDS  = 128,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        reloj,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        run,
  output logic        busy,
  output logic [1:0]  err,
  output logic [15:0] words_loaded
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [15:0] LEN_MAX  = 16'(IMEM_WORDS);

  state_t      state;
  err_t        err_q;
  logic        run_q;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] len_rx;
  logic [7:0]  csum;
  logic [31:0] tmo_cnt;
  logic        accept;
  logic        is_sync;
  logic        counting;
  logic        tmo_hit;
  logic        word_done;
  logic [31:0] word;

  assign accept   = rx_valid && rx_ready;
  assign is_sync  = (rx_data == SYNC_BYTE);
  assign len_rx   = {len_hi, rx_data};
  assign counting = state inside {LEN_HI, LEN_LO, DATA, CSUM};
  assign tmo_hit  = counting && (tmo_cnt == TMO_LAST);

  // A reload sync byte must drop run combinationally in its own handshake cycle
  assign run          = run_q && !(state == RUN && accept && is_sync);
  assign busy         = state inside {LEN_HI, LEN_LO, DATA, WRITE, CSUM};
  assign err          = err_q;
  assign im_wdata     = word;

  byte_packer u_packer (
    .clk       (reloj),
    .reset     (reset),
    .clear     (accept && state == LEN_LO),
    .load      (accept && state == DATA),
    .din       (rx_data),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge reloj) begin
    if (reset) begin
      state        <= IDLE;
      err_q        <= ERR_NONE;
      run_q        <= 1'b0;
      rx_ready     <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      words_loaded <= '0;
      len_hi       <= '0;
      len          <= '0;
      csum         <= '0;
      tmo_cnt      <= '0;
    end else begin
      rx_ready <= 1'b1;
      im_we    <= 1'b0;

      if (accept || !counting) tmo_cnt <= '0;
      else                     tmo_cnt <= tmo_cnt + 32'd1;

      if (tmo_hit && !accept) begin
        err_q <= ERR_TMO;
        state <= ERROR;
      end else begin
        case (state)
          IDLE: if (accept && is_sync) state <= LEN_HI;
          LEN_HI: begin
            if (accept) begin
              len_hi <= rx_data;
              state  <= LEN_LO;
            end
          end
          LEN_LO: begin
            if (accept) begin
              len          <= len_rx;
              csum         <= '0;
              words_loaded <= '0;
              if (len_rx > LEN_MAX) begin
                err_q <= ERR_LEN;
                state <= ERROR;
              end else if (len_rx == '0) begin
                state <= CSUM;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (accept) begin
              csum <= csum ^ rx_data;
              // Stall intake for the single WRITE cycle that follows a completed word
              if (word_done) begin
                state    <= WRITE;
                rx_ready <= 1'b0;
                im_we    <= 1'b1;
                im_addr  <= {14'b0, words_loaded, 2'b00};
              end
            end
          end
          WRITE: begin
            words_loaded <= words_loaded + 16'd1;
            state        <= (words_loaded + 16'd1 == len) ? CSUM : DATA;
          end
          CSUM: begin
            if (accept) begin
              if (rx_data == csum) begin
                run_q <= 1'b1;
                state <= RUN;
              end else begin
                err_q <= ERR_CSUM;
                state <= ERROR;
              end
            end
          end
          RUN: begin
            if (accept && is_sync) begin
              run_q        <= 1'b0;
              words_loaded <= '0;
              err_q        <= ERR_NONE;
              state        <= LEN_HI;
            end
          end
          ERROR: begin
            if (accept && is_sync) begin
              err_q <= ERR_NONE;
              state <= LEN_HI;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized frame stimulus for prog_loader, checked against a frame-level reference model.
module tb_prog_loader;

  logic        reloj = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        run;
  logic        busy;
  logic [1:0]  err;
  logic [15:0] words_loaded;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] pay[$];
  logic [63:0] wq[$];
  logic        prev_rst = 1'b1;

  prog_loader #(.IMEM_WORDS(128), .TIMEOUT_CYC(16)) dut (
    .reloj        (reloj),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .run          (run),
    .busy         (busy),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 reloj = ~reloj;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge reloj) prev_rst <= reset;

  // Capture every memory write; rx_ready must be low exactly in write cycles
  always @(negedge reloj) begin
    if (im_we) begin
      wq.push_back({im_addr, im_wdata});
      check("we_while_run", 32'(run), 32'd0);
    end
    if (!reset && !prev_rst) check("rdy_vs_we", 32'(rx_ready), 32'(!im_we));
  end

  function automatic logic [7:0] csum_of(input int unsigned n);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < int'(n); i++)
      c = c ^ pay[i][31:24] ^ pay[i][23:16] ^ pay[i][15:8] ^ pay[i][7:0];
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int unsigned k = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && k < 100) begin
      @(negedge reloj);
      k++;
    end
    if (k >= 100) check("rdy_wait", 32'(rx_ready), 32'd1);
    @(posedge reloj);
    @(negedge reloj);
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int unsigned maxgap);
    repeat ($urandom_range(maxgap, 0)) @(negedge reloj);
  endtask

  task automatic idle(input int unsigned n);
    rx_valid = 1'b0;
    repeat (n) @(negedge reloj);
  endtask

  task automatic send_body(input int unsigned n, input logic [7:0] delta, input int unsigned maxgap);
    logic [15:0] nn = 16'(n);
    logic [31:0] w;
    send_byte(nn[15:8]);
    gap(maxgap);
    send_byte(nn[7:0]);
    for (int i = 0; i < int'(n); i++) begin
      w = pay[i];
      for (int j = 0; j < 4; j++) begin
        gap(maxgap);
        send_byte(w[31:24]);
        w = w << 8;
      end
    end
    gap(maxgap);
    send_byte(csum_of(n) ^ delta);
  endtask

  task automatic send_frame(input int unsigned n, input logic [7:0] delta, input int unsigned maxgap);
    wq.delete();
    send_byte(8'hA5);
    gap(maxgap);
    send_body(n, delta, maxgap);
  endtask

  task automatic expect_frame(input int unsigned n, input bit bad);
    check("run", 32'(run), bad ? 32'd0 : 32'd1);
    check("err", 32'(err), bad ? 32'd2 : 32'd0);
    check("busy", 32'(busy), 32'd0);
    check("words_loaded", 32'(words_loaded), 32'(n));
    check("write_count", 32'(wq.size()), 32'(n));
    for (int i = 0; i < int'(n) && i < wq.size(); i++) begin
      check("wr_addr", wq[i][63:32], 32'(i * 4));
      check("wr_data", wq[i][31:0], pay[i]);
    end
  endtask

  task automatic expect_reset_vals();
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_im_addr", im_addr, 32'd0);
    check("rst_im_wdata", im_wdata, 32'd0);
    check("rst_run", 32'(run), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
  endtask

  initial begin
    int unsigned n;
    bit bad;
    logic [7:0] delta;

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge reloj);
    expect_reset_vals();
    reset = 1'b0;
    @(negedge reloj);

    // Non-sync bytes in IDLE are dropped
    send_byte(8'h55); send_byte(8'h55); send_byte(8'h55);
    idle(2);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_writes", 32'(wq.size()), 32'd0);

    pay = {32'h24080005, 32'h8C090004};
    send_frame(2, 8'h00, 2);
    expect_frame(2, 1'b0);
    idle(2);

    // Checksum byte 0x00 is wrong for this payload
    send_frame(2, csum_of(2), 1);
    expect_frame(2, 1'b1);
    idle(2);
    send_frame(2, 8'h00, 0);
    expect_frame(2, 1'b0);
    idle(2);

    // Oversize length, then stray payload bytes
    wq.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h81);
    check("len_err", 32'(err), 32'd1);
    check("len_busy", 32'(busy), 32'd0);
    check("len_words", 32'(words_loaded), 32'd0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle(3);
    check("len_err_hold", 32'(err), 32'd1);
    check("len_run", 32'(run), 32'd0);
    check("len_writes", 32'(wq.size()), 32'd0);

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(6, 0);
      bad = 1'($urandom_range(1, 0));
      delta = bad ? 8'($urandom_range(255, 1)) : 8'h00;
      pay.delete();
      for (int i = 0; i < int'(n); i++) pay.push_back($urandom());
      send_frame(n, delta, $urandom_range(2, 0));
      expect_frame(n, bad);
      idle($urandom_range(3, 1));
    end

    // Full-depth frame with rx_valid held high throughout
    pay.delete();
    for (int i = 0; i < 128; i++) pay.push_back($urandom());
    send_frame(128, 8'h00, 0);
    expect_frame(128, 1'b0);
    check("last_addr", wq[wq.size() - 1][63:32], 32'h1FC);
    idle(2);

    // Reload while running
    pay = {$urandom()};
    send_frame(1, 8'h00, 1);
    expect_frame(1, 1'b0);
    wq.delete();
    rx_data = 8'hA5; rx_valid = 1'b1;
    #1;
    check("reload_run_drop", 32'(run), 32'd0);
    @(posedge reloj);
    @(negedge reloj);
    rx_valid = 1'b0;
    check("reload_run", 32'(run), 32'd0);
    check("reload_busy", 32'(busy), 32'd1);
    check("reload_words", 32'(words_loaded), 32'd0);
    pay = {$urandom()};
    send_body(1, 8'h00, 1);
    expect_frame(1, 1'b0);
    idle(2);

    // Inter-byte timeout mid-word
    wq.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    repeat (14) @(negedge reloj);
    check("tmo_early", 32'(err), 32'd0);
    repeat (2) @(negedge reloj);
    check("tmo_err", 32'(err), 32'd3);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_run", 32'(run), 32'd0);
    check("tmo_writes", 32'(wq.size()), 32'd0);

    // Reset in the middle of a payload
    wq.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h24); send_byte(8'h08);
    reset = 1'b1;
    @(negedge reloj);
    expect_reset_vals();
    reset = 1'b0;
    @(negedge reloj);
    send_byte(8'h24); send_byte(8'h00); send_byte(8'h01);
    idle(2);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_writes", 32'(wq.size()), 32'd0);
    pay = {32'h24080005, 32'h8C090004};
    send_frame(2, 8'h00, 1);
    expect_frame(2, 1'b0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
